vertex_assembler: RTL

VERTEX_ASSEMBLER -- requirements
Module: vertex_assembler

---
 rtl/vertex_assembler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vertex_assembler.sv
// Vertex assembler: collects three vertex words into a triangle and computes
// its signed doubled area and bounding box. Zero-area triangles are dropped
// and counted unless DROP_DEGEN is cleared.
module vertex_assembler #(
    parameter int DROP_DEGEN = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld_in,
    input  logic [63:0]          data_in,
    output logic                 rdy_in,
    output logic                 vld_out,
    input  logic                 rdy_out,
    output logic [191:0]         tri_out,
    output logic [63:0]          bbox_out,
    output logic [34:0]          area_out,
    output logic [CNT_WIDTH-1:0] drop_count
);

    typedef enum logic [2:0] {V0, V1, V2, CALC, OUT} state_t;

    state_t r_state;
    state_t w_nextState;

    logic [63:0]          r_v0, r_v1, r_v2;
    logic [191:0]         r_tri;
    logic [63:0]          r_bbox;
    logic signed [34:0]   r_area;
    logic [CNT_WIDTH-1:0] r_dropCount;

    logic w_accept;
    logic w_drop;

    logic signed [15:0] w_x0, w_x1, w_x2, w_y0, w_y1, w_y2;
    logic signed [16:0] w_dx1, w_dx2, w_dy1, w_dy2;
    logic signed [33:0] w_p1, w_p2;
    logic signed [34:0] w_area;
    logic signed [15:0] w_xMin, w_xMax, w_yMin, w_yMax;

    // Input is only accepted while collecting vertices, so rdy_in is a pure
    // function of state and holds its V0 value during reset.
    assign rdy_in   = (r_state == V0) || (r_state == V1) || (r_state == V2);
    assign w_accept = vld_in && rdy_in;
    assign vld_out  = (r_state == OUT);

    assign w_x0 = r_v0[15:0];
    assign w_y0 = r_v0[31:16];
    assign w_x1 = r_v1[15:0];
    assign w_y1 = r_v1[31:16];
    assign w_x2 = r_v2[15:0];
    assign w_y2 = r_v2[31:16];

    // Differences are widened to 17 bits before subtracting so the full
    // 16-bit signed range never wraps; products and area are likewise exact.
    assign w_dx1 = {w_x1[15], w_x1} - {w_x0[15], w_x0};
    assign w_dx2 = {w_x2[15], w_x2} - {w_x0[15], w_x0};
    assign w_dy1 = {w_y1[15], w_y1} - {w_y0[15], w_y0};
    assign w_dy2 = {w_y2[15], w_y2} - {w_y0[15], w_y0};
    assign w_p1  = 34'(w_dx1) * 34'(w_dy2);
    assign w_p2  = 34'(w_dx2) * 34'(w_dy1);
    assign w_area = 35'(w_p1) - 35'(w_p2);

    assign w_drop = (DROP_DEGEN != 0) && (w_area == '0);

    // Signed three-way min/max of the vertex coordinates for the bounding box.
    always_comb begin
        w_xMin = w_x0;
        w_xMax = w_x0;
        w_yMin = w_y0;
        w_yMax = w_y0;
        if (w_x1 < w_xMin) w_xMin = w_x1;
        if (w_x2 < w_xMin) w_xMin = w_x2;
        if (w_x1 > w_xMax) w_xMax = w_x1;
        if (w_x2 > w_xMax) w_xMax = w_x2;
        if (w_y1 < w_yMin) w_yMin = w_y1;
        if (w_y2 < w_yMin) w_yMin = w_y2;
        if (w_y1 > w_yMax) w_yMax = w_y1;
        if (w_y2 > w_yMax) w_yMax = w_y2;
    end

    // State register; reset aborts any partially collected triangle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= V0;
        else        r_state <= w_nextState;
    end

    // Next-state logic: three vertex slots, one compute cycle, then hold the
    // result until downstream takes it (degenerate triangles skip OUT).
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            V0:      if (w_accept) w_nextState = V1;
            V1:      if (w_accept) w_nextState = V2;
            V2:      if (w_accept) w_nextState = CALC;
            CALC:    w_nextState = w_drop ? V0 : OUT;
            OUT:     if (rdy_out) w_nextState = V0;
            default: w_nextState = V0;
        endcase
    end

    // Vertex capture: the current state selects which slot the word fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= '0;
            r_v1 <= '0;
            r_v2 <= '0;
        end else if (w_accept) begin
            case (r_state)
                V0:      r_v0 <= data_in;
                V1:      r_v1 <= data_in;
                V2:      r_v2 <= data_in;
                default: ;
            endcase
        end
    end

    // Result registers load only in CALC, so they stay frozen through OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tri  <= '0;
            r_bbox <= '0;
            r_area <= '0;
        end else if (r_state == CALC) begin
            r_tri  <= {r_v2, r_v1, r_v0};
            r_bbox <= {w_yMax, w_xMax, w_yMin, w_xMin};
            r_area <= w_area;
        end
    end

    // Saturating count of discarded zero-area triangles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropCount <= '0;
        end else if ((r_state == CALC) && w_drop && (r_dropCount != '1)) begin
            r_dropCount <= r_dropCount + 1'b1;
        end
    end

    assign tri_out    = r_tri;
    assign bbox_out   = r_bbox;
    assign area_out   = r_area;
    assign drop_count = r_dropCount;

endmodule
